// File: rtl/branch_controller.sv
// Decode-stage conditional-branch resolver: stalls decode until operands are final, evaluates the
// condition, and hands a registered redirect to fetch. Optional macro BRANCH_DELAY_SLOT_EN keeps the IF instruction.
module branch_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        branch_valid,
    input  logic [1:0]  branch_type,
    input  logic        operands_ready,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    input  logic [31:0] branch_immediate,
    input  logic [31:0] pc_plus_four,
    input  logic        fetch_ready,
    output logic        stall_decode,
    output logic        redirect_valid,
    output logic [31:0] redirect_address,
    output logic        flush_fetch,
    output logic [15:0] branch_count,
    output logic [15:0] taken_count
);
    typedef enum logic [1:0] {IDLE, WAIT_OPS, REDIRECT} state_t;

    state_t      state, state_next;
    logic        eval;
    logic        taken;
    logic [31:0] target;

    always_comb begin
        taken = 1'b0;
        case (branch_type)
            2'b00: taken = (rs_value == rt_value);
            2'b01: taken = (rs_value != rt_value);
            2'b10: taken = ($signed(rs_value) <= 0);
            2'b11: taken = ($signed(rs_value) > 0);
            default: taken = 1'b0;
        endcase
    end

    assign target = pc_plus_four + {branch_immediate[29:0], 2'b00};
    assign eval   = operands_ready &
                    (((state == IDLE) & branch_valid) | (state == WAIT_OPS));

    always_comb begin
        state_next   = state;
        stall_decode = 1'b0;
        case (state)
            IDLE: begin
                if (branch_valid & !operands_ready) begin
                    state_next   = WAIT_OPS;
                    stall_decode = 1'b1;
                end else if (eval & taken) begin
                    state_next = REDIRECT;
                end
            end
            WAIT_OPS: begin
                // branch_valid is not consulted: decode is frozen on the branch.
                if (!operands_ready) stall_decode = 1'b1;
                else                 state_next   = taken ? REDIRECT : IDLE;
            end
            REDIRECT: begin
                stall_decode = 1'b1;
                if (fetch_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            redirect_address <= '0;
            branch_count     <= '0;
            taken_count      <= '0;
        end else begin
            state <= state_next;
            if (eval & taken) redirect_address <= target;
            if (eval & (branch_count != 16'hFFFF)) branch_count <= branch_count + 16'd1;
            if (eval & taken & (taken_count != 16'hFFFF)) taken_count <= taken_count + 16'd1;
        end
    end

    assign redirect_valid = (state == REDIRECT);

`ifdef BRANCH_DELAY_SLOT_EN
    assign flush_fetch = 1'b0;
`else
    assign flush_fetch = redirect_valid & fetch_ready;
`endif

endmodule

// File: tb/tb_branch_controller.sv
// Directed plus randomized bench for branch_controller, checked against a transaction-level model.
module tb_branch_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        branch_valid = 1'b0;
    logic [1:0]  branch_type = 2'b00;
    logic        operands_ready = 1'b0;
    logic [31:0] rs_value = '0, rt_value = '0, branch_immediate = '0, pc_plus_four = '0;
    logic        fetch_ready = 1'b0;
    logic        stall_decode, redirect_valid, flush_fetch;
    logic [31:0] redirect_address;
    logic [15:0] branch_count, taken_count;

    int passed = 0;
    int total  = 0;
    bit do_chk = 1'b1;

    // model: a branch is "waiting" for operands, or a redirect is "pending" at fetch
    bit          m_wait, m_pend;
    logic [31:0] m_addr;
    int          m_br, m_tk;

    branch_controller dut (
        .clock(clock), .reset(reset), .branch_valid(branch_valid), .branch_type(branch_type),
        .operands_ready(operands_ready), .rs_value(rs_value), .rt_value(rt_value),
        .branch_immediate(branch_immediate), .pc_plus_four(pc_plus_four),
        .fetch_ready(fetch_ready), .stall_decode(stall_decode), .redirect_valid(redirect_valid),
        .redirect_address(redirect_address), .flush_fetch(flush_fetch),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit cond(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (t)
            2'b00: return a == b;
            2'b01: return a != b;
            2'b10: return sa <= 0;
            default: return sa > 0;
        endcase
    endfunction

    task automatic model_reset();
        m_wait = 0; m_pend = 0; m_addr = '0; m_br = 0; m_tk = 0;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance the model across the edge.
    task automatic step(input bit bv, input logic [1:0] bt, input bit ops, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm, input logic [31:0] pc,
                        input bit fr, input bit rst = 1'b0);
        bit ev, exp_stall, exp_flush, tk;
        branch_valid = bv; branch_type = bt; operands_ready = ops; rs_value = rs; rt_value = rt;
        branch_immediate = imm; pc_plus_four = pc; fetch_ready = fr; reset = rst;
        @(negedge clock);
        ev        = !m_pend && ops && (m_wait || bv);
        exp_stall = m_pend || (!ops && (m_wait || bv));
`ifdef BRANCH_DELAY_SLOT_EN
        exp_flush = 1'b0;
`else
        exp_flush = m_pend && fr;
`endif
        if (do_chk) begin
            chk("stall_decode", {31'd0, stall_decode}, {31'd0, exp_stall});
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_pend});
            chk("flush_fetch", {31'd0, flush_fetch}, {31'd0, exp_flush});
            if (m_pend) chk("redirect_address", redirect_address, m_addr);
            chk("branch_count", {16'd0, branch_count}, m_br);
            chk("taken_count", {16'd0, taken_count}, m_tk);
        end
        tk = cond(bt, rs, rt);
        if (rst) model_reset();
        else if (m_pend) begin
            if (fr) m_pend = 0;
        end else if (ev) begin
            m_br = (m_br < 65535) ? m_br + 1 : 65535;
            m_wait = 0;
            if (tk) begin
                m_tk = (m_tk < 65535) ? m_tk + 1 : 65535;
                m_pend = 1;
                m_addr = pc + imm * 4;
            end
        end else if (bv && !ops) m_wait = 1;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input bit fr = 1'b0);
        step(0, 2'b00, 0, 0, 0, 0, 0, fr);
    endtask

    initial begin
        model_reset();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_address", redirect_address, 32'd0);
        chk("rst_stall", {31'd0, stall_decode}, 32'd0);
        chk("rst_branch_count", {16'd0, branch_count}, 32'd0);
        chk("rst_taken_count", {16'd0, taken_count}, 32'd0);

        // BEQ taken, operands ready: no stall, redirect next cycle
        step(1, 2'b00, 1, 5, 5, 32'h3, 32'h1004, 0);
        chk("beq_valid", {31'd0, redirect_valid}, 32'd1);
        chk("beq_addr", redirect_address, 32'h1010);
        chk("beq_bcnt", {16'd0, branch_count}, 32'd1);
        chk("beq_tcnt", {16'd0, taken_count}, 32'd1);
        idle(1);
        idle();

        // BNE not taken
        step(1, 2'b01, 1, 7, 7, 32'h10, 32'h2000, 0);
        chk("bne_valid", {31'd0, redirect_valid}, 32'd0);
        chk("bne_tcnt", {16'd0, taken_count}, 32'd1);

        // BGTZ negative rs after 3 unready cycles, then rs=1 taken
        repeat (3) step(1, 2'b11, 0, 32'h8000_0000, 0, 32'hFFFF_FFFF, 32'h100, 0);
        step(1, 2'b11, 1, 32'h8000_0000, 0, 32'hFFFF_FFFF, 32'h100, 0);
        chk("bgtz_neg_valid", {31'd0, redirect_valid}, 32'd0);
        repeat (3) step(1, 2'b11, 0, 32'h1, 0, 32'hFFFF_FFFF, 32'h100, 0);
        step(1, 2'b11, 1, 32'h1, 0, 32'hFFFF_FFFF, 32'h100, 0);
        chk("bgtz_pos_addr", redirect_address, 32'h0000_00FC);

        // fetch backpressure for 4 cycles, then transfer
        repeat (4) begin
            step(1, 2'b00, 1, 0, 0, 32'h40, 32'h500, 0);
            chk("hold_addr", redirect_address, 32'h0000_00FC);
        end
        step(1, 2'b00, 1, 0, 0, 32'h40, 32'h500, 1);
        chk("xfer_valid_drop", {31'd0, redirect_valid}, 32'd0);
        idle();

        // wrap, then reset while the redirect is pending
        step(1, 2'b00, 1, 9, 9, 32'h2, 32'hFFFF_FFFC, 0);
        chk("wrap_addr", redirect_address, 32'h0000_0004);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_mid_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_mid_bcnt", {16'd0, branch_count}, 32'd0);
        idle();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a, b;
            a = $urandom_range(0, 3) == 0 ? $urandom : 32'($signed($urandom_range(0, 4)) - 2);
            b = $urandom_range(0, 1) ? a : $urandom;
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 2) != 0, a, b,
                 $urandom, $urandom, $urandom_range(0, 2) == 0);
        end

        // saturation: not-taken branches every cycle
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        do_chk = 1'b0;
        for (int i = 0; i < 65540; i++) step(1, 2'b01, 1, 3, 3, 0, 0, 0);
        do_chk = 1'b1;
        chk("sat_bcnt", {16'd0, branch_count}, 32'h0000_FFFF);
        chk("sat_tcnt", {16'd0, taken_count}, 32'd0);
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_controller.md
# branch_controller

Sequences conditional-branch resolution in the decode stage: holds decode while branch operands are unresolved, evaluates the condition, computes the target as pc_plus_four + (immediate << 2), and presents a registered redirect to fetch over a valid/ready handshake. Sits between the decode register file/hazard logic and the fetch PC mux. Also keeps saturating branch and taken-branch counters for performance monitoring.

## Interface
- No parameters; all widths fixed.
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- branch_valid  input  1  decode holds a conditional branch this cycle.
- branch_type  input  2  00 BEQ, 01 BNE, 10 BLEZ, 11 BGTZ.
- operands_ready  input  1  hazard unit: rs_value/rt_value are final this cycle.
- rs_value  input  32  first operand (signed for BLEZ/BGTZ).
- rt_value  input  32  second operand (ignored for BLEZ/BGTZ).
- branch_immediate  input  32  sign-extended branch immediate.
- pc_plus_four  input  32  branch PC + 4.
- fetch_ready  input  1  fetch accepts redirect this cycle.
- stall_decode  output  1  decode must hold its instruction and all inputs above stable.
- redirect_valid  output  1  registered; redirect_address is valid.
- redirect_address  output  32  registered branch target.
- flush_fetch  output  1  kill instruction in IF (see Configuration).
- branch_count  output  16  branches evaluated, saturating.
- taken_count  output  16  branches taken, saturating.

## Operation
- States: IDLE, WAIT_OPS, REDIRECT.
- Evaluation cycle E: (IDLE & branch_valid & operands_ready) or (WAIT_OPS & operands_ready).
- IDLE: branch_valid & !operands_ready -> WAIT_OPS. E with taken -> REDIRECT. E with not-taken -> stay IDLE. branch_valid=0 -> stay.
- WAIT_OPS: !operands_ready -> stay. E taken -> REDIRECT; E not-taken -> IDLE. branch_valid ignored here (decode is stalled and holds it).
- REDIRECT: redirect_valid=1; on fetch_ready -> IDLE; else hold address and valid.
- Condition: BEQ rs==rt; BNE rs!=rt; BLEZ signed rs<=0; BGTZ signed rs>0.
- Target: pc_plus_four + (branch_immediate << 2), 32-bit, modulo 2^32 (wrap discarded; negative offsets via two's complement). Captured into redirect_address on E only when taken.
- stall_decode = (IDLE & branch_valid & !operands_ready) | (WAIT_OPS & !operands_ready) | REDIRECT. Deasserted on E so decode advances.
- Counters: on E, branch_count += 1; taken_count += 1 if taken; both saturate at 0xFFFF.

## Timing
- Reset (synchronous): state IDLE, redirect_valid 0, redirect_address 0, flush_fetch 0, both counters 0, stall_decode 0 after reset (combinational from state/inputs). Reset mid-REDIRECT drops the pending redirect.
- Latency: E in cycle N -> redirect_valid=1 in cycle N+1. Not-taken branch with ready operands: zero stall cycles.
- Handshake: transfer when redirect_valid & fetch_ready; redirect_valid falls the next cycle. redirect_address and redirect_valid must not change while valid & !fetch_ready.
- Minimum taken-branch occupancy: E cycle + 1 REDIRECT cycle; next branch can evaluate the cycle after transfer.
- fetch_ready when redirect_valid=0: ignored.
- operands_ready toggling in WAIT_OPS: only the cycle it is 1 evaluates; no partial capture.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: MIPS delay-slot semantics; instruction in IF is kept; flush_fetch constant 0.
- Undefined: no delay slot; flush_fetch=1 for exactly the transfer cycle (redirect_valid & fetch_ready), 0 otherwise.

## Test plan
- BEQ rs=rt=5, operands_ready=1, pc_plus_four=0x0000_1004, imm=0x0000_0003 -> stall_decode 0 on E; next cycle redirect_valid=1, redirect_address=0x0000_1010; branch_count=1, taken_count=1.
- BNE rs=rt=7, operands ready -> no redirect, no stall, branch_count=1, taken_count=0.
- BGTZ rs=0x8000_0000, operands_ready low 3 cycles then high, imm=0xFFFF_FFFF, pc_plus_four=0x100 -> stall_decode 1 for 3 cycles, not taken (negative rs); repeat with rs=1 -> redirect_address=0x0000_00FC.
- Taken branch with fetch_ready low 4 cycles -> redirect_valid and address held stable, stall_decode 1 throughout; transfer on fetch_ready, flush_fetch pulse 1 cycle only without BRANCH_DELAY_SLOT_EN, 0 with it.
- Wrap: pc_plus_four=0xFFFF_FFFC, imm=2 -> redirect_address=0x0000_0004.
- Reset asserted during REDIRECT -> next cycle redirect_valid 0, state IDLE, counters 0; 0x10000 evaluations -> counters stick at 0xFFFF.
